// File: rtl/clock_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_reset_sequencer_if
//  Description : Control and status bundle of the clock/reset sequencer.
//                The slave side is the sequencer. The master side is the
//                controller that drives lock and requests and observes the
//                domain resets.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       lock_lost_clr;
    logic       mem_rstn;
    logic       core_rstn;
    logic       loader_rstn;
    logic       cpu_rstn;
    logic       all_ready;
    logic       lock_lost;
    logic [2:0] seq_state;

    modport master (
        output pll_locked, soft_rst_req, lock_lost_clr,
        input  mem_rstn, core_rstn, loader_rstn, cpu_rstn,
               all_ready, lock_lost, seq_state
    );

    modport slave (
        input  pll_locked, soft_rst_req, lock_lost_clr,
        output mem_rstn, core_rstn, loader_rstn, cpu_rstn,
               all_ready, lock_lost, seq_state
    );
endinterface
`default_nettype wire

// File: rtl/clock_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : clock_reset_sequencer
//  Description : Debounces PLL lock and releases the domain resets in order
//                mem -> core -> model_loader -> cpu. All resets are pulled
//                back on lock loss or on a software reset request.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STEP_CYCLES        = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int CNT_W              = 16
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    clock_reset_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_REL_MEM   = 3'd2,
        ST_REL_CORE  = 3'd3,
        ST_REL_LDR   = 3'd4,
        ST_REL_CPU   = 3'd5,
        ST_RUN       = 3'd6,
        ST_UNUSED    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_step_last = CNT_W'(STEP_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   r_mem_rstn,    w_next_mem_rstn;
    logic                   r_core_rstn,   w_next_core_rstn;
    logic                   r_loader_rstn, w_next_loader_rstn;
    logic                   r_cpu_rstn,    w_next_cpu_rstn;
    logic                   r_all_ready,   w_next_all_ready;
    logic                   r_lock_lost,   w_next_lock_lost;
    logic                   w_in_wait;
    logic                   w_step_done;

    // Bring the asynchronous PLL lock into the clk domain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Unused code 7 behaves exactly like WAIT_LOCK, including abort exemption
    assign w_in_wait   = (r_state == ST_WAIT_LOCK) || (r_state == ST_UNUSED);
    assign w_step_done = (r_cnt == c_step_last);

    // Sequencer state, counter and every output are registered together
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_WAIT_LOCK;
            r_cnt         <= '0;
            r_mem_rstn    <= 1'b0;
            r_core_rstn   <= 1'b0;
            r_loader_rstn <= 1'b0;
            r_cpu_rstn    <= 1'b0;
            r_all_ready   <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_mem_rstn    <= w_next_mem_rstn;
            r_core_rstn   <= w_next_core_rstn;
            r_loader_rstn <= w_next_loader_rstn;
            r_cpu_rstn    <= w_next_cpu_rstn;
            r_all_ready   <= w_next_all_ready;
            r_lock_lost   <= w_next_lock_lost;
        end
    end

    // Next-state and next-output decode; lock abort outranks soft reset
    always_comb begin
        w_next_state       = r_state;
        w_next_cnt         = r_cnt;
        w_next_mem_rstn    = r_mem_rstn;
        w_next_core_rstn   = r_core_rstn;
        w_next_loader_rstn = r_loader_rstn;
        w_next_cpu_rstn    = r_cpu_rstn;
        w_next_all_ready   = r_all_ready;
        w_next_lock_lost   = r_lock_lost;

        // A clear is overridden below if a loss is flagged in the same cycle
        if (bus.lock_lost_clr) begin
            w_next_lock_lost = 1'b0;
        end

        if ((!w_lock_s && !w_in_wait) || bus.soft_rst_req) begin
            w_next_state       = ST_WAIT_LOCK;
            w_next_cnt         = '0;
            w_next_mem_rstn    = 1'b0;
            w_next_core_rstn   = 1'b0;
            w_next_loader_rstn = 1'b0;
            w_next_cpu_rstn    = 1'b0;
            w_next_all_ready   = 1'b0;
            // A drop while debouncing is only a retry, not a loss
            if (!w_lock_s && !w_in_wait && (r_state != ST_STABLE)) begin
                w_next_lock_lost = 1'b1;
            end
        end else begin
            case (r_state)
                ST_STABLE: begin
                    if (r_cnt == c_lock_last) begin
                        w_next_state    = ST_REL_MEM;
                        w_next_cnt      = '0;
                        w_next_mem_rstn = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REL_MEM: begin
                    if (w_step_done) begin
                        w_next_state     = ST_REL_CORE;
                        w_next_cnt       = '0;
                        w_next_core_rstn = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REL_CORE: begin
                    if (w_step_done) begin
                        w_next_state       = ST_REL_LDR;
                        w_next_cnt         = '0;
                        w_next_loader_rstn = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REL_LDR: begin
                    if (w_step_done) begin
                        w_next_state    = ST_REL_CPU;
                        w_next_cnt      = '0;
                        w_next_cpu_rstn = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REL_CPU: begin
                    if (w_step_done) begin
                        w_next_state     = ST_RUN;
                        w_next_cnt       = '0;
                        w_next_all_ready = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    w_next_cnt = '0;
                end
                default: begin
                    // WAIT_LOCK and the unused code
                    w_next_cnt = '0;
                    if (w_lock_s) begin
                        w_next_state = ST_STABLE;
                    end else begin
                        w_next_state = ST_WAIT_LOCK;
                    end
                end
            endcase
        end
    end

    assign bus.mem_rstn    = r_mem_rstn;
    assign bus.core_rstn   = r_core_rstn;
    assign bus.loader_rstn = r_loader_rstn;
    assign bus.cpu_rstn    = r_cpu_rstn;
    assign bus.all_ready   = r_all_ready;
    assign bus.lock_lost   = r_lock_lost;
    assign bus.seq_state   = r_state;

endmodule
`default_nettype wire
